serial_subtractor: RTL and testbench



---
 rtl/serial_subtractor.sv | 126 ++++++++++++
 tb/tb_serial_subtractor.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial N-bit subtractor, LSB first.
// Each bit goes through two half-subtractor cells; the borrow between bits is held in a register.

module half_subtractor (
  input  logic x,
  input  logic y,
  output logic di,
  output logic bo
);
  assign di = x ^ y;
  assign bo = ~x & y;
endmodule

module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             busy,
  output logic             done
);
  localparam int unsigned CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] sa_q;
  logic [WIDTH-1:0] sb_q;
  logic [WIDTH-1:0] diff_q;
  logic [WIDTH-1:0] diff_d;
  logic [CW-1:0]    cnt_q;
  logic             br_q;
  logic             br_d;
  logic             bout_q;
  logic             busy_q;
  logic             done_q;

  logic x;
  logic b1;
  logic d;
  logic b2;

  half_subtractor u_hs1 (
    .x  (sa_q[0]),
    .y  (sb_q[0]),
    .di (x),
    .bo (b1)
  );

  half_subtractor u_hs2 (
    .x  (x),
    .y  (br_q),
    .di (d),
    .bo (b2)
  );

  always_comb begin
    br_d   = b1 | b2;
    diff_d = {d, diff_q[WIDTH-1:1]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      diff_q  <= '0;
      cnt_q   <= '0;
      br_q    <= 1'b0;
      bout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            sa_q    <= a;
            sb_q    <= b;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          br_q   <= br_d;
          diff_q <= diff_d;
          sa_q   <= {1'b0, sa_q[WIDTH-1:1]};
          sb_q   <= {1'b0, sb_q[WIDTH-1:1]};
          cnt_q  <= cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            bout_q  <= br_d;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign diff = diff_q;
  assign bout = bout_q;
  assign busy = busy_q;
  assign done = done_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed and random operands on an 8-bit
// instance, plus an exhaustive back-to-back sweep on a 2-bit instance.

module tb_serial_subtractor;
  logic       clk = 1'b0;
  logic       rst8, start8, rst2, start2;
  logic [7:0] a8, b8, diff8;
  logic       bout8, busy8, done8;
  logic [1:0] a2, b2, diff2;
  logic       bout2, busy2, done2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst8), .start(start8), .a(a8), .b(b8),
    .diff(diff8), .bout(bout8), .busy(busy8), .done(done8)
  );

  serial_subtractor #(.WIDTH(2)) dut2 (
    .clk(clk), .rst(rst2), .start(start2), .a(a2), .b(b2),
    .diff(diff2), .bout(bout2), .busy(busy2), .done(done2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One 8-bit operation. pulse: extra start pulses at edges E+k (bit k). rst_at: reset at edge E+rst_at (0 = none).
  task automatic run8(input logic [7:0] ta, input logic [7:0] tb, input logic [15:0] pulse,
                      input int rst_at, input string tag);
    int done_cnt = 0;
    int done_k = 0;
    int busy_cnt = 0;
    logic [7:0] d_seen = '0;
    logic b_seen = 1'b0;
    logic [7:0] exp_d;
    logic exp_b;
    exp_d = 8'((32'(ta) - 32'(tb)) & 32'hFF);
    exp_b = (ta < tb);
    @(negedge clk);
    a8 = ta; b8 = tb; start8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if (busy8) busy_cnt++;
    for (int k = 1; k <= 9; k++) begin
      start8 = pulse[k];
      a8 = 8'hFF; b8 = 8'h00;
      rst8 = (k == rst_at);
      @(posedge clk);
      @(negedge clk);
      rst8 = 1'b0;
      if (busy8) busy_cnt++;
      if (done8) begin
        done_cnt++;
        done_k = k;
        d_seen = diff8;
        b_seen = bout8;
      end
      if (k == rst_at) begin
        check({tag, " rst diff"}, 32'(diff8), 32'h0);
        check({tag, " rst bout"}, 32'(bout8), 32'h0);
        check({tag, " rst busy"}, 32'(busy8), 32'h0);
        check({tag, " rst done"}, 32'(done8), 32'h0);
      end
    end
    start8 = 1'b0;
    @(negedge clk);
    if (done8) done_cnt++;
    if (rst_at != 0) begin
      check({tag, " no done after rst"}, 32'(done_cnt), 32'd0);
    end else begin
      check({tag, " done count"}, 32'(done_cnt), 32'd1);
      check({tag, " done latency"}, 32'(done_k), 32'd8);
      check({tag, " diff"}, 32'(d_seen), 32'(exp_d));
      check({tag, " bout"}, 32'(b_seen), 32'(exp_b));
      check({tag, " busy cycles"}, 32'(busy_cnt), 32'd9);
      check({tag, " diff hold"}, 32'(diff8), 32'(exp_d));
      check({tag, " bout hold"}, 32'(bout8), 32'(exp_b));
      check({tag, " idle busy"}, 32'(busy8), 32'd0);
    end
  endtask

  initial begin
    logic [3:0] q_a[$];
    logic [3:0] q_b[$];
    int idx;
    int last_done;
    int ndone;
    logic [1:0] pa, pb;

    rst8 = 1'b1; start8 = 1'b0; a8 = '0; b8 = '0;
    rst2 = 1'b1; start2 = 1'b0; a2 = '0; b2 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset diff", 32'(diff8), 32'h0);
    check("reset bout", 32'(bout8), 32'h0);
    check("reset busy", 32'(busy8), 32'h0);
    check("reset done", 32'(done8), 32'h0);
    rst8 = 1'b0; rst2 = 1'b0;

    run8(8'd200, 8'd55, 16'h0, 0, "200-55");
    run8(8'd55, 8'd200, 16'h0, 0, "55-200");
    run8(8'h00, 8'h01, 16'h0, 0, "0-1");
    run8(8'hA5, 8'hA5, 16'h0, 0, "A5-A5");
    run8(8'd10, 8'd3, 16'h0308, 0, "ignored starts");
    run8(8'd42, 8'd17, 16'h0, 0, "after ignored");
    run8(8'd99, 8'd11, 16'h0, 4, "midrun rst");
    run8(8'd9, 8'd4, 16'h0, 0, "after rst");
    for (int i = 0; i < 12; i++) begin
      run8(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 16'h0, 0, "random");
    end

    // 2-bit exhaustive sweep, start held high so operations run back to back.
    idx = 0; last_done = -1; ndone = 0;
    for (int cyc = 0; cyc < 200 && ndone < 16; cyc++) begin
      @(negedge clk);
      if (done2) begin
        pa = 2'(q_a.pop_front());
        pb = 2'(q_b.pop_front());
        check("w2 diff", 32'(diff2), 32'((32'(pa) - 32'(pb)) & 32'h3));
        check("w2 bout", 32'(bout2), 32'(pa < pb));
        if (last_done >= 0) check("w2 done spacing", 32'(cyc - last_done), 32'd4);
        last_done = cyc;
        ndone++;
      end
      if (!busy2) begin
        if (idx < 16) begin
          a2 = 2'(idx >> 2); b2 = 2'(idx & 3); start2 = 1'b1;
          q_a.push_back(4'(idx >> 2)); q_b.push_back(4'(idx & 3));
          idx++;
        end else begin
          start2 = 1'b0;
        end
      end
    end
    start2 = 1'b0;
    check("w2 ops completed", 32'(ndone), 32'd16);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
